// File: rtl/fg_prog_sequencer.sv
// Floating-gate programming sequencer: break-before-make run/prog switching, decoder select, timed injection pulses.
// Optional FGPROG_VERIFY_EN adds a MEAS state with a comparator strobe and early termination on meas_ge.
module fg_prog_sequencer #(
  parameter int ROW_BITS   = 5,
  parameter int COL_BITS   = 6,
  parameter int CNT_W      = 8,
  parameter int PW_W       = 12,
  parameter int SETTLE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ROW_BITS-1:0] cmd_row,
  input  logic [COL_BITS-1:0] cmd_col,
  input  logic [CNT_W-1:0]    cmd_pulses,
  input  logic [PW_W-1:0]     cmd_width,
  input  logic                abort,
  output logic [ROW_BITS-1:0] dec_row,
  output logic [COL_BITS-1:0] dec_col,
  output logic                dec_en,
  output logic                prog,
  output logic                run,
  output logic                vinj_pulse,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [CNT_W-1:0]    pulse_cnt
`ifdef FGPROG_VERIFY_EN
  ,
  input  logic                meas_ge,
  output logic                meas_strobe
`endif
);

  localparam int SW    = $clog2(SETTLE_CYC + 1);
  localparam int TMR_W = (PW_W > SW) ? PW_W : SW;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, ISOLATE, SELECT, PULSE, GAP, MEAS, RELEASE, DONE
  } state_t;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   timer, tmr_val;
  logic               tmr_load, tmr_last;
  logic               accept, pulse_inc, abort_take, more_pulses;
  logic [ROW_BITS-1:0] row_q;
  logic [COL_BITS-1:0] col_q;
  logic [CNT_W-1:0]   pulses_q;
  logic [PW_W-1:0]    width_q;
  logic               abort_q;

  assign tmr_last    = (timer == '0);
  assign accept      = cmd_valid && (state == IDLE);
  assign more_pulses = (pulse_cnt < pulses_q);

  // NOTE: every signal written here gets a default first, so no path can leave a latch behind.
  always_comb begin
    state_nxt  = state;
    tmr_load   = 1'b0;
    tmr_val    = SETTLE_LAST;
    pulse_inc  = 1'b0;
    abort_take = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        state_nxt = ISOLATE;
        tmr_load  = 1'b1;
      end
      ISOLATE, SELECT, PULSE, GAP, MEAS: begin
        if (abort) begin
          abort_take = 1'b1;
          state_nxt  = RELEASE;
          tmr_load   = 1'b1;
        end else if (tmr_last) begin
          tmr_load = 1'b1;
          unique case (state)
            ISOLATE: state_nxt = SELECT;
            SELECT:  state_nxt = (pulses_q == '0) ? RELEASE : PULSE;
            PULSE: begin
              state_nxt = GAP;
              pulse_inc = 1'b1;
            end
`ifdef FGPROG_VERIFY_EN
            GAP:     state_nxt = MEAS;
            default: state_nxt = (!meas_ge && more_pulses) ? PULSE : RELEASE;
`else
            default: state_nxt = more_pulses ? PULSE : RELEASE;
`endif
          endcase
          if (state_nxt == PULSE) tmr_val = TMR_W'(width_q - PW_W'(1));
        end
      end
      RELEASE: if (tmr_last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      pulses_q  <= '0;
      width_q   <= '0;
      pulse_cnt <= '0;
      abort_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (tmr_load)       timer <= tmr_val;
      else if (!tmr_last) timer <= timer - TMR_W'(1);
      if (accept) begin
        row_q     <= cmd_row;
        col_q     <= cmd_col;
        pulses_q  <= cmd_pulses;
        width_q   <= (cmd_width == '0) ? PW_W'(1) : cmd_width;
        pulse_cnt <= '0;
        abort_q   <= 1'b0;
      end
      if (pulse_inc && (pulse_cnt != '1)) pulse_cnt <= pulse_cnt + CNT_W'(1);
      if (abort_take) abort_q <= 1'b1;
    end
  end

  // Outputs decode straight from state so an asynchronous reset takes effect in the same cycle.
  assign cmd_ready  = (state == IDLE);
  assign busy       = ~cmd_ready;
  assign run        = (state == IDLE) || (state == DONE);
  assign prog       = (state == SELECT) || (state == PULSE) || (state == GAP) || (state == MEAS);
  assign dec_en     = prog;
  assign vinj_pulse = (state == PULSE);
  assign done       = (state == DONE);
  assign aborted    = done && abort_q;
  assign dec_row    = row_q;
  assign dec_col    = col_q;
`ifdef FGPROG_VERIFY_EN
  assign meas_strobe = (state == MEAS) && tmr_last;
`endif

endmodule
